// File: rtl/bcd_rr_arbiter_if.sv
// rtl/bcd_rr_arbiter_if.sv - grant handshake bundle for bcd_rr_arbiter (i_lock present with BCD_ARB_LOCK_EN)
interface bcd_rr_arbiter_if #(
    parameter int N_REQ = 10
);
    logic             i_en;
    logic [N_REQ-1:0] i_req;
    logic             i_ready;
`ifdef BCD_ARB_LOCK_EN
    logic             i_lock;
`endif
    logic             o_valid;
    logic [N_REQ-1:0] o_gnt;
    logic [3:0]       o_idx;
    logic             o_busy;

`ifdef BCD_ARB_LOCK_EN
    modport slave  (input  i_en, i_req, i_ready, i_lock, output o_valid, o_gnt, o_idx, o_busy);
    modport master (output i_en, i_req, i_ready, i_lock, input  o_valid, o_gnt, o_idx, o_busy);
`else
    modport slave  (input  i_en, i_req, i_ready, output o_valid, o_gnt, o_idx, o_busy);
    modport master (output i_en, i_req, i_ready, input  o_valid, o_gnt, o_idx, o_busy);
`endif
endinterface

// File: rtl/bcd_rr_arbiter.sv
// rtl/bcd_rr_arbiter.sv - round-robin arbiter issuing one-hot + BCD index grants over valid/ready
// Optional burst lock of the last-served pointer is enabled by defining BCD_ARB_LOCK_EN.
module bcd_rr_arbiter #(
    parameter int N_REQ   = 10,
    parameter int RST_PTR = 9
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    bcd_rr_arbiter_if.slave bus
);
    typedef enum logic {S_IDLE, S_GRANT} state_t;

    localparam logic [4:0] LP_N = 5'(N_REQ);

    state_t           r_state, w_nxt_state;
    logic [3:0]       r_ptr, w_nxt_ptr;
    logic [N_REQ-1:0] r_gnt, w_nxt_gnt;
    logic [3:0]       r_idx, w_nxt_idx;

    logic [15:0]      w_req_ext;
    logic [4:0]       w_sum;
    logic [4:0]       w_pos;
    logic             w_found;
    logic [3:0]       w_win;
    logic             w_hold_ptr;

    assign w_req_ext = 16'(bus.i_req);

`ifdef BCD_ARB_LOCK_EN
    assign w_hold_ptr = bus.i_lock;
`else
    assign w_hold_ptr = 1'b0;
`endif

    // Scan ptr+1, ptr+2, ... modulo N_REQ; first set request wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + 5'(k);
            w_pos = (w_sum >= LP_N) ? (w_sum - LP_N) : w_sum;
            if (!w_found && w_req_ext[w_pos[3:0]]) begin
                w_found = 1'b1;
                w_win   = w_pos[3:0];
            end
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        w_nxt_gnt   = r_gnt;
        w_nxt_idx   = r_idx;
        case (r_state)
            S_IDLE: begin
                w_nxt_gnt = '0;
                w_nxt_idx = '0;
                if (bus.i_en && w_found) begin
                    w_nxt_state = S_GRANT;
                    w_nxt_gnt   = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
                    w_nxt_idx   = w_win;
                end
            end
            S_GRANT: begin
                if (bus.i_ready) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_gnt   = '0;
                    w_nxt_idx   = '0;
                    if (!w_hold_ptr) begin
                        w_nxt_ptr = r_idx;
                    end
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_gnt   = '0;
                w_nxt_idx   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= 4'(RST_PTR);
            r_gnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_ptr   <= w_nxt_ptr;
            r_gnt   <= w_nxt_gnt;
            r_idx   <= w_nxt_idx;
        end
    end

    assign bus.o_valid = (r_state == S_GRANT);
    assign bus.o_busy  = (r_state == S_GRANT);
    assign bus.o_gnt   = r_gnt;
    assign bus.o_idx   = r_idx;
endmodule

// File: tb/tb_bcd_rr_arbiter.sv
// tb/tb_bcd_rr_arbiter.sv - directed and random checks of bcd_rr_arbiter against a reference model
module tb_bcd_rr_arbiter;
    localparam int N = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_err    = 0;
    int   n_checks = 0;

    int   m_ptr;
    int   m_idx;
    bit   m_valid;
    int   seen[$];

    bcd_rr_arbiter_if #(.N_REQ(N)) bus ();

    bcd_rr_arbiter #(.N_REQ(N), .RST_PTR(9)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 9;
        m_idx   = 0;
        m_valid = 0;
    endtask

    function automatic int pick(int ptr, logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge(logic en, logic [N-1:0] req, logic rdy, logic lk);
        if (!m_valid) begin
            if (en && req != '0) begin
                m_idx   = pick(m_ptr, req);
                m_valid = 1;
            end
        end else if (rdy) begin
            if (!lk) m_ptr = m_idx;
            m_valid = 0;
            m_idx   = 0;
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, ".valid"}, 32'(bus.o_valid), 32'(m_valid));
        chk({tag, ".busy"},  32'(bus.o_busy),  32'(m_valid));
        chk({tag, ".idx"},   32'(bus.o_idx),   m_valid ? 32'(m_idx) : 32'd0);
        chk({tag, ".gnt"},   32'(bus.o_gnt),   m_valid ? (32'd1 << m_idx) : 32'd0);
    endtask

    task automatic step(string tag, logic en, logic [N-1:0] req, logic rdy, logic lk);
        bus.i_en    = en;
        bus.i_req   = req;
        bus.i_ready = rdy;
`ifdef BCD_ARB_LOCK_EN
        bus.i_lock  = lk;
`endif
        @(posedge clk);
        if (rst_n) model_edge(en, req, rdy, lk);
        #1;
        check_model(tag);
    endtask

    initial begin
        logic [N-1:0] r_req;
        logic         r_en;
        logic         r_rdy;
        logic         r_lk;

        bus.i_en    = 1'b1;
        bus.i_req   = 10'h3FF;
        bus.i_ready = 1'b0;
`ifdef BCD_ARB_LOCK_EN
        bus.i_lock  = 1'b0;
`endif
        model_reset();

        // Reset held with all requests active
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("rst.valid", 32'(bus.o_valid), 32'd0);
            chk("rst.gnt",   32'(bus.o_gnt),   32'd0);
            chk("rst.idx",   32'(bus.o_idx),   32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Rotation through all ten requesters
        for (int c = 0; c < 22; c++) begin
            step("rot", 1'b1, 10'h3FF, 1'b1, 1'b0);
            if (bus.o_valid) seen.push_back(int'(bus.o_idx));
        end
        chk("rot.count", 32'(seen.size()), 32'd11);
        for (int g = 0; g < 11 && g < seen.size(); g++) begin
            chk("rot.seq", 32'(seen[g]), 32'(g % 10));
        end

        // Short reset to restart from ptr=9
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Hold while not ready
        for (int c = 0; c < 6; c++) step("hold", 1'b1, 10'b0000100100, 1'b0, 1'b0);
        chk("hold.idx", 32'(bus.o_idx), 32'd2);
        chk("hold.gnt", 32'(bus.o_gnt), 32'h004);
        step("hold.acc", 1'b1, 10'b0000100100, 1'b1, 1'b0);
        step("hold.nxt", 1'b1, 10'b0000100100, 1'b0, 1'b0);
        chk("hold.idx5", 32'(bus.o_idx), 32'd5);
        step("hold.acc2", 1'b1, 10'b0000100100, 1'b1, 1'b0);

        // Wrap and sparse requests
        step("wrap.g9", 1'b1, 10'h200, 1'b0, 1'b0);
        chk("wrap.idx9", 32'(bus.o_idx), 32'd9);
        step("wrap.a9", 1'b1, 10'h200, 1'b1, 1'b0);
        step("wrap.g1", 1'b1, 10'b1000000010, 1'b0, 1'b0);
        chk("wrap.idx1", 32'(bus.o_idx), 32'd1);
        step("wrap.a1", 1'b1, 10'b1000000010, 1'b1, 1'b0);
        step("wrap.g9b", 1'b1, 10'b1000000010, 1'b0, 1'b0);
        chk("wrap.idx9b", 32'(bus.o_idx), 32'd9);
        step("wrap.a9b", 1'b1, 10'b1000000010, 1'b1, 1'b0);

        // Enable low blocks new grants but does not abort one in flight
        for (int c = 0; c < 3; c++) step("en.off", 1'b0, 10'h001, 1'b1, 1'b0);
        chk("en.off.valid", 32'(bus.o_valid), 32'd0);
        step("en.g", 1'b1, 10'h001, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) step("en.hold", 1'b0, 10'h000, 1'b0, 1'b0);
        chk("en.hold.valid", 32'(bus.o_valid), 32'd1);
        step("en.acc", 1'b0, 10'h000, 1'b1, 1'b0);

        // Reset during GRANT aborts immediately
        step("ab.g", 1'b1, 10'h010, 1'b0, 1'b0);
        chk("ab.pre", 32'(bus.o_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ab.valid", 32'(bus.o_valid), 32'd0);
        chk("ab.gnt",   32'(bus.o_gnt),   32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("ab.next", 1'b1, 10'h3FF, 1'b0, 1'b0);
        chk("ab.idx0", 32'(bus.o_idx), 32'd0);
        step("ab.acc", 1'b1, 10'h3FF, 1'b1, 1'b0);

`ifdef BCD_ARB_LOCK_EN
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("lk.g", 1'b1, 10'h00C, 1'b0, 1'b0);
        chk("lk.idx2", 32'(bus.o_idx), 32'd2);
        step("lk.acc", 1'b1, 10'h00C, 1'b1, 1'b1);
        step("lk.g2", 1'b1, 10'h00C, 1'b0, 1'b0);
        chk("lk.idx2b", 32'(bus.o_idx), 32'd2);
        step("lk.acc2", 1'b1, 10'h00C, 1'b1, 1'b0);
        step("lk.g3", 1'b1, 10'h00C, 1'b0, 1'b0);
        chk("lk.idx3", 32'(bus.o_idx), 32'd3);
        step("lk.acc3", 1'b1, 10'h00C, 1'b1, 1'b0);
`endif

        // Randomised traffic against the model
        for (int c = 0; c < 400; c++) begin
            r_req = 10'($urandom);
            if ($urandom_range(0, 3) == 0) r_req = 10'(1 << $urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0) r_req = '0;
            r_en  = ($urandom_range(0, 7) != 0);
            r_rdy = 1'($urandom_range(0, 1));
`ifdef BCD_ARB_LOCK_EN
            r_lk  = ($urandom_range(0, 3) == 0);
`else
            r_lk  = 1'b0;
`endif
            step("rand", r_en, r_req, r_rdy, r_lk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "timeout");
    end
endmodule
